// File: rtl/ppl_lane_sched.sv
// ppl_lane_sched: frame scan scheduler for a multi-lane ray-march pipeline.
// Walks the pixel-address space once per frame, hands pixels to the lowest
// free march lane, counts march steps per lane (forcing a timeout at
// MAX_STEPS) and serialises finished results onto one backpressured stream.
//
// Output stream handshake: a result is transferred in every cycle where
// out_valid and out_ready are both high. Once out_valid is raised it stays
// high, and out_addr/out_hit/out_steps/out_lane stay unchanged, until that
// transfer happens; out_valid never waits on out_ready.
module ppl_lane_sched #(
  parameter int H_DISP      = 1280,
  parameter int V_DISP      = 720,
  parameter int LANES       = 4,
  parameter int MAX_STEPS   = 15,
  parameter int PREP_CYCLES = 8,
  localparam int TOTAL = H_DISP * V_DISP,
  localparam int AW    = $clog2(TOTAL),
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int SW    = $clog2(MAX_STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pause,
  output logic             busy,
  output logic             prepare,
  output logic             frame_done,
  output logic [LANES-1:0] lane_start,
  output logic [AW-1:0]    issue_addr,
  output logic [LANES-1:0] lane_en,
  input  logic [LANES-1:0] lane_hit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_addr,
  output logic             out_hit,
  output logic [SW-1:0]    out_steps,
  output logic [LW-1:0]    out_lane
);

  localparam int PW = $clog2(PREP_CYCLES + 1);

  // Top-level frame states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PREP  = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Per-lane states
  localparam logic [1:0] LN_FREE  = 2'd0;
  localparam logic [1:0] LN_MARCH = 2'd1;
  localparam logic [1:0] LN_WAIT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] prep_cnt_q, prep_cnt_d;
  logic [AW-1:0] next_addr_q, next_addr_d;
  logic [LW-1:0] rr_ptr_q, rr_ptr_d;

  logic [1:0]       lane_st_q   [LANES];
  logic [1:0]       lane_st_d   [LANES];
  logic [SW-1:0]    lane_cnt_q  [LANES];
  logic [SW-1:0]    lane_cnt_d  [LANES];
  logic [AW-1:0]    lane_addr_q [LANES];
  logic [AW-1:0]    lane_addr_d [LANES];
  logic [LANES-1:0] lane_res_hit_q, lane_res_hit_d;

  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_hit_q, out_hit_d;
  logic [SW-1:0] out_steps_q, out_steps_d;
  logic [LW-1:0] out_lane_q, out_lane_d;

  logic          free_found;
  logic [LW-1:0] free_idx;
  logic          issue_fire;
  logic          wait_found;
  logic [LW-1:0] retire_idx;
  logic          retire_fire;
  logic          out_load;
  logic          all_free;
  int            ridx;

  assign busy      = (state_q != ST_IDLE);
  assign prepare   = (state_q == ST_PREP);
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_hit   = out_hit_q;
  assign out_steps = out_steps_q;
  assign out_lane  = out_lane_q;

  // Issue: lowest-index free lane takes the next raster address
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    all_free   = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (lane_st_q[i] != LN_FREE) begin
        all_free = 1'b0;
      end else if (!free_found) begin
        free_found = 1'b1;
        free_idx   = LW'(i);
      end
    end
    issue_fire = (state_q == ST_SCAN) && !pause && free_found;
    lane_start = '0;
    issue_addr = '0;
    if (issue_fire) begin
      lane_start[free_idx] = 1'b1;
      issue_addr           = next_addr_q;
    end
  end

  // Retire: first waiting lane at or after the round-robin pointer
  always_comb begin
    wait_found = 1'b0;
    retire_idx = '0;
    ridx       = 0;
    for (int k = 0; k < LANES; k++) begin
      ridx = (int'(rr_ptr_q) + k) % LANES;
      if (!wait_found && (lane_st_q[ridx] == LN_WAIT)) begin
        wait_found = 1'b1;
        retire_idx = LW'(ridx);
      end
    end
    out_load    = !out_valid_q || out_ready;
    retire_fire = out_load && wait_found;
    rr_ptr_d    = rr_ptr_q;
    if (retire_fire) begin
      rr_ptr_d = LW'((int'(retire_idx) + 1) % LANES);
    end
  end

  // Output register: load a retired result or empty on acceptance
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_hit_d   = out_hit_q;
    out_steps_d = out_steps_q;
    out_lane_d  = out_lane_q;
    if (retire_fire) begin
      out_valid_d = 1'b1;
      out_addr_d  = lane_addr_q[retire_idx];
      out_hit_d   = lane_res_hit_q[retire_idx];
      out_steps_d = lane_cnt_q[retire_idx];
      out_lane_d  = retire_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Per-lane march control: step strobe, step counting, hit/timeout
  always_comb begin
    lane_en        = '0;
    lane_res_hit_d = lane_res_hit_q;
    for (int i = 0; i < LANES; i++) begin
      lane_st_d[i]   = lane_st_q[i];
      lane_cnt_d[i]  = lane_cnt_q[i];
      lane_addr_d[i] = lane_addr_q[i];
      lane_en[i]     = (lane_st_q[i] == LN_MARCH) && !pause;
      case (lane_st_q[i])
        LN_FREE: begin
          if (lane_start[i]) begin
            lane_st_d[i]   = LN_MARCH;
            lane_cnt_d[i]  = '0;
            lane_addr_d[i] = next_addr_q;
          end
        end
        LN_MARCH: begin
          if (lane_en[i]) begin
            lane_cnt_d[i] = lane_cnt_q[i] + SW'(1);
            if (lane_hit[i]) begin
              lane_st_d[i]      = LN_WAIT;
              lane_res_hit_d[i] = 1'b1;
            end else if ((lane_cnt_q[i] + SW'(1)) == SW'(MAX_STEPS)) begin
              lane_st_d[i]      = LN_WAIT;
              lane_res_hit_d[i] = 1'b0;
            end
          end
        end
        LN_WAIT: begin
          if (retire_fire && (retire_idx == LW'(i))) begin
            lane_st_d[i] = LN_FREE;
          end
        end
        default: lane_st_d[i] = LN_FREE;
      endcase
    end
  end

  // Frame FSM: IDLE -> PREP -> SCAN -> DRAIN -> IDLE
  always_comb begin
    state_d     = state_q;
    prep_cnt_d  = prep_cnt_q;
    next_addr_d = next_addr_q;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d     = ST_PREP;
          prep_cnt_d  = '0;
          next_addr_d = '0;
        end
      end
      ST_PREP: begin
        if (prep_cnt_q == PW'(PREP_CYCLES - 1)) begin
          state_d = ST_SCAN;
        end else begin
          prep_cnt_d = prep_cnt_q + PW'(1);
        end
      end
      ST_SCAN: begin
        if (issue_fire) begin
          next_addr_d = next_addr_q + AW'(1);
          if (next_addr_q == AW'(TOTAL - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (all_free && (!out_valid_q || out_ready)) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      prep_cnt_q     <= '0;
      next_addr_q    <= '0;
      rr_ptr_q       <= '0;
      lane_res_hit_q <= '0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_hit_q      <= 1'b0;
      out_steps_q    <= '0;
      out_lane_q     <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_st_q[i]   <= LN_FREE;
        lane_cnt_q[i]  <= '0;
        lane_addr_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      prep_cnt_q     <= prep_cnt_d;
      next_addr_q    <= next_addr_d;
      rr_ptr_q       <= rr_ptr_d;
      lane_res_hit_q <= lane_res_hit_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_hit_q      <= out_hit_d;
      out_steps_q    <= out_steps_d;
      out_lane_q     <= out_lane_d;
      for (int i = 0; i < LANES; i++) begin
        lane_st_q[i]   <= lane_st_d[i];
        lane_cnt_q[i]  <= lane_cnt_d[i];
        lane_addr_q[i] <= lane_addr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ppl_lane_sched.sv
// tb_ppl_lane_sched: directed bench for ppl_lane_sched on a 4x2 raster with
// two lanes, step budget 4 and a 3-cycle prepare phase.
module tb_ppl_lane_sched;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int L     = 2;
  localparam int MS    = 4;
  localparam int PC    = 3;
  localparam int TOTAL = H * V;
  localparam int AW    = 3;
  localparam int LW    = 1;
  localparam int SW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          frame_start;
  logic          pause;
  logic          busy;
  logic          prepare;
  logic          frame_done;
  logic [L-1:0]  lane_start;
  logic [AW-1:0] issue_addr;
  logic [L-1:0]  lane_en;
  logic [L-1:0]  lane_hit;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic          out_hit;
  logic [SW-1:0] out_steps;
  logic [LW-1:0] out_lane;

  ppl_lane_sched #(
    .H_DISP(H), .V_DISP(V), .LANES(L), .MAX_STEPS(MS), .PREP_CYCLES(PC)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pause(pause),
    .busy(busy), .prepare(prepare), .frame_done(frame_done),
    .lane_start(lane_start), .issue_addr(issue_addr), .lane_en(lane_en),
    .lane_hit(lane_hit), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_hit(out_hit), .out_steps(out_steps),
    .out_lane(out_lane)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- result monitor ----------------
  logic          mon_clr = 1'b0;
  logic [AW-1:0] res_addr_q[$];
  logic          res_hit_q[$];
  logic [SW-1:0] res_steps_q[$];
  int            res_en_q[$];
  int            fd_cnt = 0;
  int            run_cnt[L];

  always @(negedge clk) begin
    if (mon_clr) begin
      res_addr_q.delete();
      res_hit_q.delete();
      res_steps_q.delete();
      res_en_q.delete();
      fd_cnt = 0;
      for (int i = 0; i < L; i++) run_cnt[i] = 0;
    end else begin
      if (out_valid && out_ready) begin
        res_addr_q.push_back(out_addr);
        res_hit_q.push_back(out_hit);
        res_steps_q.push_back(out_steps);
        res_en_q.push_back(run_cnt[out_lane]);
      end
      if (frame_done) fd_cnt++;
      for (int i = 0; i < L; i++) begin
        if (lane_start[i]) run_cnt[i] = 0;
        if (lane_en[i]) run_cnt[i]++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check_results(input string tag, input logic exp_hit,
                               input logic [SW-1:0] exp_steps, input int exp_en,
                               input bit do_steps);
    logic [AW-1:0] exp_q[$];
    int pos;
    chk({tag, "_count"}, 32'(res_addr_q.size()), 32'(TOTAL));
    exp_q.delete();
    for (int a = 0; a < TOTAL; a++) exp_q.push_back(AW'(a));
    for (int j = 0; j < res_addr_q.size(); j++) begin
      pos = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (pos < 0 && exp_q[k] == res_addr_q[j]) pos = k;
      end
      chk({tag, "_addr_once"}, 32'(pos >= 0), 32'd1);
      if (pos >= 0) exp_q.delete(pos);
      chk({tag, "_hit"}, 32'(res_hit_q[j]), 32'(exp_hit));
      if (do_steps) chk({tag, "_steps"}, 32'(res_steps_q[j]), 32'(exp_steps));
      if (exp_en > 0) chk({tag, "_en_cycles"}, 32'(res_en_q[j]), 32'(exp_en));
    end
    chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
  endtask

  // frame_start, prepare window and first issue; returns at the second SCAN cycle
  task automatic start_frame(input string tag);
    mon_clr = 1'b1;
    frame_start = 1'b1;
    to_sample();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    next_cyc();
    mon_clr = 1'b0;
    frame_start = 1'b0;
    for (int k = 0; k < PC; k++) begin
      to_sample();
      chk({tag, "_prep"}, 32'(prepare), 32'd1);
      chk({tag, "_prep_busy"}, 32'(busy), 32'd1);
      chk({tag, "_prep_nostart"}, 32'(lane_start), 32'd0);
      next_cyc();
    end
    to_sample();
    chk({tag, "_s0_prep"}, 32'(prepare), 32'd0);
    chk({tag, "_s0_start"}, 32'(lane_start), 32'd1);
    chk({tag, "_s0_addr"}, 32'(issue_addr), 32'd0);
    chk({tag, "_s0_busy"}, 32'(busy), 32'd1);
    next_cyc();
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      to_sample();
      if (frame_done) seen = 1'b1;
      else next_cyc();
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    next_cyc();
    to_sample();
    chk({tag, "_after_busy"}, 32'(busy), 32'd0);
    chk({tag, "_after_done"}, 32'(frame_done), 32'd0);
    next_cyc();
    chk({tag, "_done_pulses"}, 32'(fd_cnt), 32'd1);
  endtask

  task automatic chk_out(input string tag, input int lane, input int addr,
                         input int hit, input int steps);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lane"}, 32'(out_lane), 32'(lane));
    chk({tag, "_addr"}, 32'(out_addr), 32'(addr));
    chk({tag, "_hit"}, 32'(out_hit), 32'(hit));
    chk({tag, "_steps"}, 32'(out_steps), 32'(steps));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; frame_start = 1'b0; pause = 1'b0;
    lane_hit = '0; out_ready = 1'b0;
    repeat (3) next_cyc();
    to_sample();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prepare", 32'(prepare), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_start", 32'(lane_start), 32'd0);
    chk("rst_en", 32'(lane_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    next_cyc();
    rst = 1'b0;

    // Hits on every step: 8 one-step results
    lane_hit = 2'b11; out_ready = 1'b1;
    start_frame("a");
    to_sample();
    chk("a_s1_start", 32'(lane_start), 32'd2);
    chk("a_s1_addr", 32'(issue_addr), 32'd1);
    chk("a_s1_en", 32'(lane_en), 32'd1);
    next_cyc();
    wait_done("a");
    check_results("a", 1'b1, 3'd1, 1, 1'b1);

    // No hits: every ray times out after 4 enabled steps
    lane_hit = 2'b00;
    start_frame("b");
    wait_done("b");
    check_results("b", 1'b0, 3'd4, 4, 1'b1);

    // Simultaneous hits: lane 0 retires first, twice
    lane_hit = 2'b00;
    start_frame("c");
    to_sample(); next_cyc();                   // S1
    lane_hit = 2'b11; to_sample(); next_cyc(); // S2
    lane_hit = 2'b00; to_sample();             // S3
    chk("c_s3_valid", 32'(out_valid), 32'd0);
    chk("c_s3_en", 32'(lane_en), 32'd0);
    next_cyc();
    to_sample();                               // S4
    chk_out("c_s4", 0, 0, 1, 2);
    chk("c_s4_start", 32'(lane_start), 32'd1);
    chk("c_s4_iaddr", 32'(issue_addr), 32'd2);
    next_cyc();
    to_sample();                               // S5
    chk_out("c_s5", 1, 1, 1, 1);
    chk("c_s5_start", 32'(lane_start), 32'd2);
    chk("c_s5_iaddr", 32'(issue_addr), 32'd3);
    next_cyc();
    lane_hit = 2'b11; to_sample(); next_cyc(); // S6
    lane_hit = 2'b00; to_sample(); next_cyc(); // S7
    to_sample(); chk_out("c_s8", 0, 2, 1, 2); next_cyc();
    to_sample(); chk_out("c_s9", 1, 3, 1, 1); next_cyc();
    lane_hit = 2'b11;
    wait_done("c");
    check_results("c", 1'b1, 3'd0, 0, 1'b0);

    // Backpressure for 10 cycles: output held, no lane re-issued
    lane_hit = 2'b11;
    start_frame("d");
    to_sample(); next_cyc();  // S1
    to_sample(); next_cyc();  // S2
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      to_sample();
      chk_out("d_stall", 0, 0, 1, 1);
      if (k == 0) begin
        chk("d_s3_start", 32'(lane_start), 32'd1);
        chk("d_s3_iaddr", 32'(issue_addr), 32'd2);
      end
      if (k >= 2) begin
        chk("d_stall_nostart", 32'(lane_start), 32'd0);
        chk("d_stall_en", 32'(lane_en), 32'd0);
      end
      next_cyc();
    end
    out_ready = 1'b1;
    wait_done("d");
    check_results("d", 1'b1, 3'd1, 0, 1'b1);

    // Pause for 5 cycles mid-march with an ignored hit pulse
    lane_hit = 2'b00;
    start_frame("e");
    to_sample(); next_cyc();  // S1
    to_sample(); next_cyc();  // S2
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      lane_hit = (k == 1) ? 2'b11 : 2'b00;
      to_sample();
      chk("e_pause_en", 32'(lane_en), 32'd0);
      chk("e_pause_start", 32'(lane_start), 32'd0);
      chk("e_pause_valid", 32'(out_valid), 32'd0);
      next_cyc();
    end
    pause = 1'b0; lane_hit = 2'b00;
    to_sample(); chk("e_s8_en", 32'(lane_en), 32'd3); next_cyc();
    to_sample(); chk("e_s9_en", 32'(lane_en), 32'd3); next_cyc();
    to_sample();
    chk("e_s10_en", 32'(lane_en), 32'd2);
    chk("e_s10_valid", 32'(out_valid), 32'd0);
    next_cyc();
    to_sample();
    chk_out("e_s11", 0, 0, 0, 4);
    chk("e_s11_start", 32'(lane_start), 32'd1);
    chk("e_s11_iaddr", 32'(issue_addr), 32'd2);
    next_cyc();
    to_sample(); chk_out("e_s12", 1, 1, 0, 4); next_cyc();
    wait_done("e");
    check_results("e", 1'b0, 3'd4, 4, 1'b1);

    // Reset during SCAN aborts the frame; a new frame restarts at 0
    lane_hit = 2'b11;
    start_frame("f");
    to_sample(); next_cyc();  // S1
    to_sample(); next_cyc();  // S2
    rst = 1'b1;
    to_sample(); next_cyc();  // S3
    rst = 1'b0;
    to_sample();
    chk("f_rst_busy", 32'(busy), 32'd0);
    chk("f_rst_prepare", 32'(prepare), 32'd0);
    chk("f_rst_done", 32'(frame_done), 32'd0);
    chk("f_rst_start", 32'(lane_start), 32'd0);
    chk("f_rst_en", 32'(lane_en), 32'd0);
    chk("f_rst_valid", 32'(out_valid), 32'd0);
    chk("f_rst_oaddr", 32'(out_addr), 32'd0);
    chk("f_rst_osteps", 32'(out_steps), 32'd0);
    chk("f_rst_ohit", 32'(out_hit), 32'd0);
    chk("f_rst_olane", 32'(out_lane), 32'd0);
    next_cyc();
    for (int k = 0; k < 4; k++) begin
      to_sample();
      chk("f_idle_busy", 32'(busy), 32'd0);
      next_cyc();
    end
    chk("f_no_done", 32'(fd_cnt), 32'd0);
    start_frame("g");
    wait_done("g");
    check_results("g", 1'b1, 3'd1, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
